// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration APB bridge.
package fll_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   // paddr[8:7] selects which FLL port (or the local block) an access goes to
   localparam logic [1:0] TGT_SOC   = 2'd0;
   localparam logic [1:0] TGT_PER   = 2'd1;
   localparam logic [1:0] TGT_CLU   = 2'd2;
   localparam logic [1:0] TGT_LOCAL = 2'd3;

   // local register word addresses (paddr[6:2])
   localparam logic [4:0] REG_LOCK      = 5'd0;
   localparam logic [4:0] REG_LOCK_LOST = 5'd1;
   localparam logic [4:0] REG_ERR       = 5'd2;
   localparam logic [4:0] REG_IRQ_EN    = 5'd3;

   localparam int NUM_FLL = 3;

   // one-hot request vector for an FLL target; the local target maps to no request
   function automatic logic [NUM_FLL-1:0] tgt_onehot(input logic [1:0] tgt);
      logic [NUM_FLL-1:0] oh;
      case (tgt)
         TGT_SOC: oh = 3'b001;
         TGT_PER: oh = 3'b010;
         TGT_CLU: oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/fll_lock_monitor.sv
// Synchronises the FLL lock inputs, detects loss of lock and keeps a sticky,
// write-one-to-clear record of it. A new loss event beats a simultaneous clear.
module fll_lock_monitor #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] lock_raw,
   input  logic [WIDTH-1:0] clear,
   output logic [WIDTH-1:0] lock_sync,
   output logic [WIDTH-1:0] lock_lost
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  lock_d;
   logic [WIDTH-1:0]                  fall;

   assign lock_sync = sync_q[SYNC_STAGES-1];
   assign fall      = lock_d & ~lock_sync;

   // synchroniser chain, delayed copy for edge detect, and sticky loss flags
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= '0;
         lock_d    <= '0;
         lock_lost <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], lock_raw};
         lock_d    <= lock_sync;
         lock_lost <= (lock_lost & ~clear) | fall;
      end
   end

endmodule

// File: rtl/fll_cfg_apb_bridge.sv
// APB slave that turns accesses into FLL config port transactions (req/wrn/add/data
// with ack), times out hung accesses, and hosts a small local status block for FLL
// lock loss, timeout errors and the lock interrupt.
//
// Handshake: an APB access is psel_i & penable_i; it completes on the cycle where
// pready_o is high. Local accesses complete in the same cycle; FLL accesses hold
// fll_req_o[target] until the matching fll_ack_i bit (or a timeout), then pulse
// pready_o for exactly one cycle.
module fll_cfg_apb_bridge
   import fll_cfg_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYC    = 256,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [31:0]               pwdata_i,
   output logic [31:0]               prdata_o,
   output logic                      pready_o,
   output logic                      pslverr_o,
   output logic [2:0]                fll_req_o,
   output logic                      fll_wrn_o,
   output logic [4:0]                fll_add_o,
   output logic [31:0]               fll_data_o,
   input  logic [2:0]                fll_ack_i,
   input  logic [95:0]               fll_r_data_i,
   input  logic [2:0]                fll_lock_i,
   output logic                      lock_irq_o
);

   localparam int              CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state;
   logic [1:0]       tgt;
   logic [1:0]       tgt_q;
   logic [4:0]       reg_add;
   logic [CNT_W-1:0] cnt;
   logic             access;
   logic             ack_hit;
   logic             timeout;
   logic [31:0]      ack_data;
   logic [31:0]      rdata_q;
   logic             pready_q;
   logic             pslverr_q;

   logic             local_hit;
   logic             local_wr;
   logic [31:0]      local_rdata;
   logic             local_err;
   logic [2:0]       lost_clr;
   logic [2:0]       err_clr;
   logic [2:0]       err_set;
   logic [2:0]       err_q;
   logic [2:0]       irq_en_q;
   logic [2:0]       lock_sync;
   logic [2:0]       lock_lost;
   logic             unused_ok;

   assign tgt     = paddr_i[8:7];
   assign reg_add = paddr_i[6:2];
   assign access  = psel_i & penable_i & ~rst_i;

   // only the requested port's ack counts; req is zero outside REQ so stray acks fall away
   assign ack_hit = |(fll_ack_i & fll_req_o);
   assign timeout = (state == REQ) & ~ack_hit & (cnt == CNT_MAX);
   assign err_set = timeout ? fll_req_o : 3'b000;

   assign local_hit = (state == IDLE) & access & (tgt == TGT_LOCAL);
   assign local_wr  = local_hit & pwrite_i;

   assign unused_ok = ^{paddr_i, pwdata_i[31:3]};

   // read-data slice belonging to the FLL currently being served
   always_comb begin
      ack_data = 32'h0;
      case (tgt_q)
         TGT_SOC: ack_data = fll_r_data_i[31:0];
         TGT_PER: ack_data = fll_r_data_i[63:32];
         TGT_CLU: ack_data = fll_r_data_i[95:64];
         default: ack_data = 32'h0;
      endcase
   end

   // local register decode: read mux, W1C strobes and bad-address error
   always_comb begin
      local_rdata = 32'h0;
      local_err   = 1'b0;
      lost_clr    = 3'b000;
      err_clr     = 3'b000;
      if (local_hit) begin
         case (reg_add)
            REG_LOCK: begin
               local_rdata = {29'b0, lock_sync};
            end
            REG_LOCK_LOST: begin
               local_rdata = {29'b0, lock_lost};
               if (pwrite_i) lost_clr = pwdata_i[2:0];
            end
            REG_ERR: begin
               local_rdata = {29'b0, err_q};
               if (pwrite_i) err_clr = pwdata_i[2:0];
            end
            REG_IRQ_EN: begin
               local_rdata = {29'b0, irq_en_q};
            end
            default: begin
               local_err = 1'b1;
            end
         endcase
      end
   end

   // transaction FSM: launch request, wait for ack or timeout, one-cycle response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         tgt_q      <= TGT_SOC;
         fll_req_o  <= 3'b000;
         fll_wrn_o  <= 1'b0;
         fll_add_o  <= 5'd0;
         fll_data_o <= 32'h0;
         cnt        <= '0;
         rdata_q    <= 32'h0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               rdata_q   <= 32'h0;
               cnt       <= '0;
               if (access && (tgt != TGT_LOCAL)) begin
                  tgt_q      <= tgt;
                  fll_wrn_o  <= ~pwrite_i;
                  fll_add_o  <= reg_add;
                  fll_data_o <= pwdata_i;
                  fll_req_o  <= tgt_onehot(tgt);
                  state      <= REQ;
               end
            end
            REQ: begin
               if (ack_hit) begin
                  fll_req_o <= 3'b000;
                  rdata_q   <= fll_wrn_o ? ack_data : 32'h0;
                  pready_q  <= 1'b1;
                  pslverr_q <= 1'b0;
                  state     <= RESP;
               end else if (timeout) begin
                  fll_req_o <= 3'b000;
                  rdata_q   <= 32'h0;
                  pready_q  <= 1'b1;
                  pslverr_q <= 1'b1;
                  state     <= RESP;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               rdata_q   <= 32'h0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // sticky timeout flags and interrupt enable; a new timeout beats a same-cycle clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q    <= 3'b000;
         irq_en_q <= 3'b000;
      end else begin
         err_q <= (err_q & ~err_clr) | err_set;
         if (local_wr && (reg_add == REG_IRQ_EN)) irq_en_q <= pwdata_i[2:0];
      end
   end

   // registered interrupt level
   always_ff @(posedge clk_i) begin
      if (rst_i) lock_irq_o <= 1'b0;
      else       lock_irq_o <= |(lock_lost & irq_en_q);
   end

   fll_lock_monitor #(
      .WIDTH       (3),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_lock_monitor (
      .clk       (clk_i),
      .rst       (rst_i),
      .lock_raw  (fll_lock_i),
      .clear     (lost_clr),
      .lock_sync (lock_sync),
      .lock_lost (lock_lost)
   );

   assign pready_o  = pready_q | local_hit;
   assign prdata_o  = rdata_q | local_rdata;
   assign pslverr_o = pslverr_q | local_err;

endmodule

// File: tb/tb_fll_cfg_apb_bridge.sv
// Directed bench for the FLL config APB bridge.
module tb_fll_cfg_apb_bridge;

   localparam int AW  = 12;
   localparam int TO  = 16;
   localparam int SYN = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] paddr;
   logic          psel, penable, pwrite;
   logic [31:0]   pwdata;
   logic [31:0]   prdata;
   logic          pready, pslverr;
   logic [2:0]    fll_req;
   logic          fll_wrn;
   logic [4:0]    fll_add;
   logic [31:0]   fll_data;
   logic [2:0]    fll_ack;
   logic [95:0]   fll_r_data;
   logic [2:0]    fll_lock;
   logic          lock_irq;

   int checks = 0;
   int errors = 0;

   // results of the last access
   int          lat, req_cnt;
   logic [31:0] rd;
   logic        perr, rdy, hold_ok, rdy_after;
   logic [2:0]  req0, req_at_rdy;
   logic [4:0]  add0;
   logic        wrn0;
   logic [31:0] data0;

   fll_cfg_apb_bridge #(
      .APB_ADDR_WIDTH (AW),
      .TIMEOUT_CYC    (TO),
      .SYNC_STAGES    (SYN)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .paddr_i      (paddr),
      .psel_i       (psel),
      .penable_i    (penable),
      .pwrite_i     (pwrite),
      .pwdata_i     (pwdata),
      .prdata_o     (prdata),
      .pready_o     (pready),
      .pslverr_o    (pslverr),
      .fll_req_o    (fll_req),
      .fll_wrn_o    (fll_wrn),
      .fll_add_o    (fll_add),
      .fll_data_o   (fll_data),
      .fll_ack_i    (fll_ack),
      .fll_r_data_i (fll_r_data),
      .fll_lock_i   (fll_lock),
      .lock_irq_o   (lock_irq)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // local register access; response sampled in the access cycle
   task automatic local_rw(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata);
      @(negedge clk);
      paddr = addr; pwrite = wr; pwdata = wdata; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #1;
      rdy = pready; rd = prdata; perr = pslverr;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   // FLL access; k counts cycles since req rose, ack driven in cycle ack_at
   task automatic fll_access(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                             input int ack_at, input logic [2:0] ack_bit,
                             input logic [2:0] spur, input int drop_at);
      lat = -1; req_cnt = 0; hold_ok = 1'b1; rd = 32'hx; perr = 1'bx; req_at_rdy = 3'bx;
      @(negedge clk);
      paddr = addr; pwrite = wr; pwdata = wdata; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (k == 0) begin
            req0 = fll_req; add0 = fll_add; wrn0 = fll_wrn; data0 = fll_data;
         end
         if (fll_req != 3'b000) begin
            req_cnt++;
            if (fll_add !== add0 || fll_wrn !== wrn0 || fll_data !== data0) hold_ok = 1'b0;
         end
         if (pready) begin
            lat = k; rd = prdata; perr = pslverr; req_at_rdy = fll_req;
            break;
         end
         fll_ack = (k == ack_at) ? ack_bit : spur;
         if (k == drop_at) begin
            psel = 1'b0; penable = 1'b0;
         end
      end
      fll_ack = 3'b000; psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      rdy_after = pready;
   endtask

   initial begin
      rst = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = 32'h0;
      fll_ack = 3'b000; fll_lock = 3'b111;
      fll_r_data = {32'h1234_5678, 32'hAAAA_5555, 32'hCCCC_3333};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_req", {29'b0, fll_req}, 32'h0);
      chk("rst_pready", {31'b0, pready}, 32'h0);
      chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_irq", {31'b0, lock_irq}, 32'h0);
      chk("rst_add_wrn", {26'b0, fll_wrn, fll_add}, 32'h0);
      chk("rst_data", fll_data, 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("irq_idle", {31'b0, lock_irq}, 32'h0);

      // LOCK register, same-cycle ready
      local_rw(12'h180, 1'b0, 32'h0);
      chk("lock_rdy", {31'b0, rdy}, 32'h1);
      chk("lock_val", rd, 32'h7);
      chk("lock_err", {31'b0, perr}, 32'h0);

      // per write, ack after 3 cycles
      fll_access(12'h084, 1'b1, 32'hDEAD_BEEF, 3, 3'b010, 3'b000, -1);
      chk("pw_req", {29'b0, req0}, 32'h2);
      chk("pw_wrn", {31'b0, wrn0}, 32'h0);
      chk("pw_add", {27'b0, add0}, 32'h1);
      chk("pw_data", data0, 32'hDEAD_BEEF);
      chk("pw_hold", {31'b0, hold_ok}, 32'h1);
      chk("pw_lat", lat, 32'd4);
      chk("pw_req_cnt", req_cnt, 32'd4);
      chk("pw_slverr", {31'b0, perr}, 32'h0);
      chk("pw_rdata", rd, 32'h0);
      chk("pw_rdy_once", {31'b0, rdy_after}, 32'h0);

      // cluster read, ack after 1 cycle
      fll_access(12'h114, 1'b0, 32'h0, 1, 3'b100, 3'b000, -1);
      chk("cr_req", {29'b0, req0}, 32'h4);
      chk("cr_wrn", {31'b0, wrn0}, 32'h1);
      chk("cr_add", {27'b0, add0}, 32'h5);
      chk("cr_lat", lat, 32'd2);
      chk("cr_rdata", rd, 32'h1234_5678);
      chk("cr_req_low", {29'b0, req_at_rdy}, 32'h0);
      chk("cr_slverr", {31'b0, perr}, 32'h0);

      // per read with spurious soc acks; real ack at cycle 3
      fll_access(12'h08C, 1'b0, 32'h0, 3, 3'b010, 3'b001, -1);
      chk("spur_lat", lat, 32'd4);
      chk("spur_rdata", rd, 32'hAAAA_5555);
      chk("spur_add", {27'b0, add0}, 32'h3);

      // psel drops mid-transaction; still one pready pulse
      fll_access(12'h004, 1'b0, 32'h0, 2, 3'b001, 3'b000, 1);
      chk("drop_lat", lat, 32'd3);
      chk("drop_rdata", rd, 32'hCCCC_3333);
      chk("drop_rdy_once", {31'b0, rdy_after}, 32'h0);

      // soc read, never acked: timeout
      fll_access(12'h000, 1'b0, 32'h0, -1, 3'b000, 3'b000, -1);
      chk("to_req_cnt", req_cnt, TO);
      chk("to_lat", lat, TO);
      chk("to_slverr", {31'b0, perr}, 32'h1);
      chk("to_rdata", rd, 32'h0);
      local_rw(12'h188, 1'b0, 32'h0);
      chk("err_after_to", rd, 32'h1);
      local_rw(12'h188, 1'b1, 32'h1);
      chk("err_w1c_rdy", {31'b0, rdy}, 32'h1);
      local_rw(12'h188, 1'b0, 32'h0);
      chk("err_cleared", rd, 32'h0);

      // undefined local address
      local_rw(12'h190, 1'b0, 32'h0);
      chk("bad_rdy", {31'b0, rdy}, 32'h1);
      chk("bad_err", {31'b0, perr}, 32'h1);
      chk("bad_rdata", rd, 32'h0);

      // IRQ_EN
      local_rw(12'h18C, 1'b1, 32'h4);
      local_rw(12'h18C, 1'b0, 32'h0);
      chk("irq_en_rb", rd, 32'h4);
      chk("irq_en_no_loss", {31'b0, lock_irq}, 32'h0);

      // lock[2] falls: LOST set at edge 3, irq at edge 4
      @(negedge clk);
      fll_lock = 3'b011;
      @(negedge clk);
      chk("fall_e1_irq", {31'b0, lock_irq}, 32'h0);
      @(negedge clk);
      chk("fall_e2_irq", {31'b0, lock_irq}, 32'h0);
      @(negedge clk);
      chk("fall_e3_irq", {31'b0, lock_irq}, 32'h0);
      @(negedge clk);
      chk("fall_e4_irq", {31'b0, lock_irq}, 32'h1);
      local_rw(12'h184, 1'b0, 32'h0);
      chk("lost_val", rd, 32'h4);
      local_rw(12'h180, 1'b0, 32'h0);
      chk("lock_after_fall", rd, 32'h3);
      local_rw(12'h184, 1'b1, 32'h4);
      local_rw(12'h184, 1'b0, 32'h0);
      chk("lost_w1c", rd, 32'h0);
      chk("irq_w1c", {31'b0, lock_irq}, 32'h0);

      // W1C landing on the same edge as a new fall: set wins
      fll_lock = 3'b111;
      repeat (5) @(negedge clk);
      fll_lock = 3'b011;
      paddr = 12'h184; pwrite = 1'b1; pwdata = 32'h4; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      local_rw(12'h184, 1'b0, 32'h0);
      chk("lost_set_wins", rd, 32'h4);
      chk("irq_set_wins", {31'b0, lock_irq}, 32'h1);
      local_rw(12'h184, 1'b1, 32'h4);
      fll_lock = 3'b111;

      // reset during REQ, then a late ack
      @(negedge clk);
      paddr = 12'h084; pwrite = 1'b1; pwdata = 32'h5555_0000; psel = 1'b1; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      chk("rq_req_up", {29'b0, fll_req}, 32'h2);
      @(negedge clk);
      rst = 1'b1; psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("rq_req_rst", {29'b0, fll_req}, 32'h0);
      rst = 1'b0;
      fll_ack = 3'b010;
      @(negedge clk);
      fll_ack = 3'b000;
      chk("rq_late_ack1", {31'b0, pready}, 32'h0);
      @(negedge clk);
      chk("rq_late_ack2", {31'b0, pready}, 32'h0);
      chk("rq_req_idle", {29'b0, fll_req}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
